div_16: RTL and testbench

DIV_16 -- requirements
Module: div_16

---
 rtl/div_16.sv | 166 ++++++++++++++++
 tb/tb_div_16.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_16.sv
// div_16: iterative radix-2 restoring divider, 16-bit operands.
// One quotient bit per BUSY cycle; 16 BUSY cycles per division.
// Division by zero short-circuits straight from IDLE to DONE.
// Optional feature macro: DIV_SIGNED_EN. When defined, operands are two's
// complement and the result truncates toward zero. When undefined, the
// block is unsigned only.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE (and never while sys_rst_n is low);
// out_valid is high only in DONE, and the result is held stable until
// out_valid && out_ready, on which edge the block returns to IDLE.
module div_16 #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] rem_q;      // partial remainder, always < divisor
    logic [WIDTH-1:0] dvd_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q;      // registered divisor (magnitude)
    logic [3:0]       cnt_q;      // iteration counter, wraps 15 -> 0

    logic [WIDTH:0]   shifted;    // 17-bit trial value {rem, dvd msb}
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             accept;
    logic             last_iter;

    assign in_ready  = (state_q == IDLE) && sys_rst_n;
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;
    assign accept    = in_valid && in_ready;
    assign last_iter = (state_q == BUSY) && (cnt_q == 4'd15);

    // One restoring step: shift, trial-subtract, keep if non-negative.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dsr_q};
        take     = ~diff[WIDTH];
        rem_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_next = {dvd_q[WIDTH-2:0], take};
    end

`ifdef DIV_SIGNED_EN
    logic quot_neg_q;   // operand signs differ
    logic rem_neg_q;    // remainder follows the dividend's sign

    // Divide magnitudes; restore signs on the final iteration.
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        quot_fix     = quot_neg_q ? (~dvd_next + 1'b1) : dvd_next;
        rem_fix      = rem_neg_q  ? (~rem_next + 1'b1) : rem_next;
    end

    // Capture operand signs at accept.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else if (accept) begin
            quot_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg_q  <= dividend[WIDTH-1];
        end
    end
`else
    // Unsigned: operands and results pass straight through.
    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        quot_fix     = dvd_next;
        rem_fix      = rem_next;
    end
`endif

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in BUSY, publish result on entry to DONE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= 4'd0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            rem_q <= '0;
            dvd_q <= dividend_mag;
            dsr_q <= divisor_mag;
            cnt_q <= 4'd0;
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end else if (state_q == BUSY) begin
            rem_q <= rem_next;
            dvd_q <= dvd_next;
            cnt_q <= cnt_q + 4'd1;
            if (last_iter) begin
                quotient  <= quot_fix;
                remainder <= rem_fix;
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_16.sv
// tb_div_16: self-checking bench for div_16 (unsigned build by default,
// signed cases added when DIV_SIGNED_EN is defined).
module tb_div_16;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic [1:0]  dbg_state;

    logic [32:0] exp_q[$];   // {div_zero, quotient, remainder}
    int          n_checks;
    int          n_errors;

    div_16 #(.WIDTH(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // Clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: C-style truncating division, div-by-zero convention.
    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q;
        logic [15:0] r;
        if (b == 16'd0) return {1'b1, 16'hFFFF, a};
`ifdef DIV_SIGNED_EN
        begin
            int sa;
            int sb;
            int qi;
            int ri;
            sa = int'($signed(a));
            sb = int'($signed(b));
            qi = sa / sb;
            ri = sa % sb;
            q  = qi[15:0];
            r  = ri[15:0];
        end
`else
        q = a / b;
        r = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    // Drive one operation, check latency, result, hold behaviour and handshake.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        int          n;
        int          exp_lat;
        logic [32:0] got;
        logic [32:0] exp;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check("ready_before_op", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge sys_clk); #1;
        exp_q.push_back(model(a, b));
        check("in_ready_after_accept", in_ready, 0);
        // Keep in_valid high with junk operands: both must be ignored.
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge sys_clk); #1;
            n++;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
        end
        in_valid = 1'b0;
        exp_lat = (b == 16'd0) ? 0 : 16;
        check("latency", n, exp_lat);
        if (out_valid) begin
            got = {div_zero, quotient, remainder};
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("result", got, exp);
            end else begin
                check("queue_underflow", 0, 1);
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge sys_clk); #1;
                check("hold_stable", {div_zero, quotient, remainder}, got);
                check("hold_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(posedge sys_clk); #1;
            out_ready = 1'b0;
            check("in_ready_after_handshake", in_ready, 1);
            check("out_valid_after_handshake", out_valid, 0);
        end else begin
            check("timeout", 0, 1);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 16'd0;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_state", dbg_state, 0);
        sys_rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Directed cases
        do_op(16'd1000, 16'd7, 0);
        do_op(16'hFFFF, 16'd1, 0);
        do_op(16'h0003, 16'h0010, 0);
        do_op(16'd5, 16'd0, 3);
        do_op(16'd1000, 16'd7, 10);
        do_op(16'd0, 16'd3, 0);
        do_op(16'hFFFF, 16'hFFFF, 0);
`ifdef DIV_SIGNED_EN
        do_op(16'hFFF9, 16'd2, 0);
        do_op(16'h8000, 16'hFFFF, 0);
        do_op(16'h8000, 16'd0, 0);
        do_op(16'd7, 16'hFFFE, 0);
`endif

        // Random cases
        for (int i = 0; i < 10; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            do_op(a, b, $urandom_range(0, 3));
        end

        // Reset pulse in the middle of BUSY aborts the operation
        in_valid = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd7;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge sys_clk);
        #1;
        check("busy_before_abort", dbg_state, 1);
        sys_rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_state", dbg_state, 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        #1;
        check("in_ready_after_abort", in_ready, 1);
        do_op(16'd100, 16'd9, 0);
        repeat (20) begin
            @(posedge sys_clk); #1;
            check("no_spurious_result", out_valid, 0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
